// File: rtl/sim_frame_ctrl.sv
// Frame tracker feeding the sim dump block: filtered VS fall detection, download gating,
// dump window and finish request. Define FRAME_TIMEOUT_EN to build in the frame watchdog.
module sim_frame_ctrl #(
  parameter int unsigned FILTER     = 4,
  parameter logic [31:0] DUMP_START = 32'd0,
  parameter logic [31:0] DUMP_STOP  = 32'hFFFF_FFFF,
  parameter logic [31:0] MAXFRAME   = 32'd0,
  parameter logic [23:0] TIMEOUT    = 24'd2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        VGA_VS,
  input  logic        led,
  input  logic        loadrom,
  output logic [31:0] frame_cnt,
  output logic        vs_fall,
  output logic        dump_en,
  output logic        finish,
  output logic        timeout
);

  typedef enum logic [1:0] {WAIT_DWN, ARMED, RUN, DONE} state_t;

  localparam logic [3:0] FILT_LAST = 4'(FILTER) - 4'd1;

  state_t      state, state_nxt;
  logic        vs_filt, vs_filt_d;
  logic [3:0]  filt_cnt;
  logic        led_d;
  logic        fall_det, led_rise, led_fall;
  logic        finish_set, wd_hit;
  logic        in_run, cnt_inc, cnt_clr;

  // VS deglitch: a new level must persist FILTER consecutive samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_filt   <= 1'b0;
      vs_filt_d <= 1'b0;
      filt_cnt  <= '0;
      led_d     <= 1'b0;
    end else begin
      vs_filt_d <= vs_filt;
      led_d     <= led;
      if (VGA_VS == vs_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        vs_filt  <= VGA_VS;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  // led_d resets low so a led already high at release reads as a rising edge
  assign fall_det   = vs_filt_d & ~vs_filt;
  assign led_rise   = led & ~led_d;
  assign led_fall   = ~led & led_d;
  assign finish_set = (MAXFRAME != 32'd0) && (frame_cnt == MAXFRAME);

`ifdef FRAME_TIMEOUT_EN
  logic [23:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == RUN && !fall_det) wd_cnt <= wd_cnt + 24'd1;
      else                           wd_cnt <= '0;
      if (wd_hit) timeout <= 1'b1;
    end
  end

  assign wd_hit = (state == RUN) && !fall_det && (wd_cnt == TIMEOUT - 24'd1);
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= loadrom ? WAIT_DWN : RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_DWN: if (led_rise) state_nxt = ARMED;
      ARMED:    if (led_fall) state_nxt = RUN;
      RUN: begin
        if (led_rise)                  state_nxt = ARMED;
        else if (finish_set || wd_hit) state_nxt = DONE;
      end
      default:  state_nxt = DONE;
    endcase
  end

  // a re-download edge outranks a coincident frame edge
  always_comb begin
    in_run  = (state == RUN);
    cnt_clr = in_run && led_rise;
    cnt_inc = in_run && !led_rise && fall_det && (frame_cnt != '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      vs_fall   <= 1'b0;
      dump_en   <= 1'b0;
      finish    <= 1'b0;
    end else begin
      vs_fall <= fall_det;
      if (cnt_clr)      frame_cnt <= '0;
      else if (cnt_inc) frame_cnt <= frame_cnt + 32'd1;
      dump_en <= in_run && (frame_cnt >= DUMP_START) && (frame_cnt < DUMP_STOP);
      finish  <= finish | finish_set | wd_hit;
    end
  end

endmodule

// File: tb/tb_sim_frame_ctrl.sv
// Bench for sim_frame_ctrl: two differently parameterised instances share one stimulus
// stream and are checked every cycle against a sample-history reference model.
module tb_sim_frame_ctrl;

  logic clk = 1'b0;
  logic rst, vs, led, loadrom;

  logic [31:0] a_frame, b_frame;
  logic a_vsf, a_den, a_fin, a_to;
  logic b_vsf, b_den, b_fin, b_to;

  int n_checks = 0;
  int n_fail   = 0;
  int a_falls  = 0;
  int b_dump_hi = 0;

`ifdef FRAME_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  sim_frame_ctrl #(.FILTER(4), .DUMP_START(32'd2), .DUMP_STOP(32'd4),
                   .MAXFRAME(32'd5), .TIMEOUT(24'd500)) dut_a (
    .clk(clk), .rst(rst), .VGA_VS(vs), .led(led), .loadrom(loadrom),
    .frame_cnt(a_frame), .vs_fall(a_vsf), .dump_en(a_den), .finish(a_fin), .timeout(a_to));

  sim_frame_ctrl #(.FILTER(3), .DUMP_START(32'd3), .DUMP_STOP(32'd2),
                   .MAXFRAME(32'd0), .TIMEOUT(24'd300)) dut_b (
    .clk(clk), .rst(rst), .VGA_VS(vs), .led(led), .loadrom(loadrom),
    .frame_cnt(b_frame), .vs_fall(b_vsf), .dump_en(b_den), .finish(b_fin), .timeout(b_to));

  // mode: 0 waiting for download, 1 downloading, 2 counting, 3 finished
  typedef struct {
    int        mode;
    bit        filt, pend, ledp;
    bit [15:0] hist;
    int        nsamp;
    bit [31:0] frame;
    bit        vsf, den, fin, to;
    int        wd;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, bit r, bit v, bit l, bit ld, int f,
                                bit [31:0] ds, bit [31:0] de, bit [31:0] mx,
                                int tmo, bit to_en);
    mdl_t n = m;
    bit alldiff, newf, rise, lfall, fset, hit;
    if (r) begin
      n.mode = ld ? 0 : 2;
      n.filt = 0; n.pend = 0; n.ledp = 0; n.hist = '0; n.nsamp = 0;
      n.frame = 0; n.vsf = 0; n.den = 0; n.fin = 0; n.to = 0; n.wd = 0;
      return n;
    end
    // level accepted once the last f raw samples all disagree with it
    n.hist  = {m.hist[14:0], v};
    n.nsamp = (m.nsamp < 16) ? m.nsamp + 1 : 16;
    alldiff = (n.nsamp >= f);
    for (int i = 0; i < f; i++) if (n.hist[i] == m.filt) alldiff = 0;
    newf    = alldiff ? !m.filt : m.filt;
    n.filt  = newf;
    n.vsf   = m.pend;
    n.pend  = m.filt && !newf;
    rise    = l && !m.ledp;
    lfall   = !l && m.ledp;
    n.ledp  = l;
    fset    = (mx != 0) && (m.frame == mx);
    hit     = to_en && (m.mode == 2) && !m.pend && (m.wd == tmo - 1);
    n.wd    = ((m.mode == 2) && !m.pend) ? m.wd + 1 : 0;
    n.den   = (m.mode == 2) && (m.frame >= ds) && (m.frame < de);
    n.fin   = m.fin || fset || hit;
    n.to    = m.to || hit;
    case (m.mode)
      0: if (rise) n.mode = 1;
      1: if (lfall) n.mode = 2;
      2: begin
        if (rise) begin
          n.mode = 1; n.frame = 0;
        end else begin
          if (m.pend && m.frame != 32'hFFFF_FFFF) n.frame = m.frame + 1;
          if (fset || hit) n.mode = 3;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    ma = step(ma, rst, vs, led, loadrom, 4, 32'd2, 32'd4, 32'd5, 500, TO_EN);
    mb = step(mb, rst, vs, led, loadrom, 3, 32'd3, 32'd2, 32'd0, 300, TO_EN);
    #2;
    if (a_vsf === 1'b1) a_falls++;
    if (b_den === 1'b1) b_dump_hi++;
    chk("a.frame_cnt", a_frame, ma.frame);
    chk("a.vs_fall",   32'(a_vsf), 32'(ma.vsf));
    chk("a.dump_en",   32'(a_den), 32'(ma.den));
    chk("a.finish",    32'(a_fin), 32'(ma.fin));
    chk("a.timeout",   32'(a_to),  32'(ma.to));
    chk("b.frame_cnt", b_frame, mb.frame);
    chk("b.vs_fall",   32'(b_vsf), 32'(mb.vsf));
    chk("b.dump_en",   32'(b_den), 32'(mb.den));
    chk("b.finish",    32'(b_fin), 32'(mb.fin));
    chk("b.timeout",   32'(b_to),  32'(mb.to));
  end

  task automatic drive_vs(bit v, int n);
    @(negedge clk);
    vs = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic frame(int hi, int lo);
    drive_vs(1'b1, hi);
    drive_vs(1'b0, lo);
  endtask

  task automatic rand_frame();
    frame(int'($urandom_range(20, 60)), int'($urandom_range(20, 60)));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".a_frame"}, a_frame, 32'd0);
    chk({tag, ".a_outs"},  {28'd0, a_vsf, a_den, a_fin, a_to}, 32'd0);
    chk({tag, ".b_frame"}, b_frame, 32'd0);
    chk({tag, ".b_outs"},  {28'd0, b_vsf, b_den, b_fin, b_to}, 32'd0);
  endtask

  task automatic do_reset(bit ld, bit l);
    @(negedge clk);
    rst = 1'b1; loadrom = ld; led = l; vs = 1'b0;
    #1;
    chk_all_zero("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int falls0;
    rst = 1'b1; vs = 1'b0; led = 1'b0; loadrom = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // free-running count: a finishes at 5, b keeps counting
    repeat (7) rand_frame();
    chk("lit.a_frame_sat5", a_frame, 32'd5);
    chk("lit.a_finish",     32'(a_fin), 32'd1);
    chk("lit.b_frame7",     b_frame, 32'd7);

    // b sees a VS fall on the same edge as a led rise (FILTER=3)
    drive_vs(1'b1, 20);
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
    led = 1'b1;
    @(posedge clk);
    #1;
    chk("lit.b_coinc_vsfall", 32'(b_vsf), 32'd1);
    chk("lit.b_coinc_frame",  b_frame, 32'd0);
    drive_vs(1'b1, 30);

    // download-gated counting; VS low across reset release must not count
    do_reset(1'b1, 1'b0);
    falls0 = a_falls;
    drive_vs(1'b0, 20);
    chk("lit.no_fall_at_release", 32'(a_falls - falls0), 32'd0);
    repeat (3) rand_frame();
    chk("lit.wait_a_frame", a_frame, 32'd0);
    chk("lit.wait_b_frame", b_frame, 32'd0);
    @(negedge clk) led = 1'b1;
    frame(100, 150);
    frame(100, 150);
    @(negedge clk) led = 1'b0;
    rand_frame();
    rand_frame();
    chk("lit.dl_a_frame2", a_frame, 32'd2);
    chk("lit.dl_b_frame2", b_frame, 32'd2);
    chk("lit.dl_a_dump",   32'(a_den), 32'd1);

    // VS stopped for a long stretch
    drive_vs(1'b0, 400);
`ifdef FRAME_TIMEOUT_EN
    chk("lit.b_timeout", {30'd0, b_to, b_fin}, 32'd3);
    chk("lit.a_no_timeout", 32'(a_to), 32'd0);
`else
    chk("lit.b_no_timeout", 32'(b_to), 32'd0);
`endif
    chk("lit.stall_b_frame", b_frame, 32'd2);

    // led already high when reset releases
    do_reset(1'b1, 1'b1);
    drive_vs(1'b0, 10);
    @(negedge clk) led = 1'b0;
    frame(30, 30);
    chk("lit.led_hi_rel_a", a_frame, 32'd1);
    chk("lit.led_hi_rel_b", b_frame, 32'd1);

    // glitch widths around the filter thresholds
    do_reset(1'b0, 1'b0);
    drive_vs(1'b1, 20);
    drive_vs(1'b0, 3);
    drive_vs(1'b1, 20);
    chk("lit.glitch3_a", a_frame, 32'd0);
    chk("lit.glitch3_b", b_frame, 32'd1);
    drive_vs(1'b0, 4);
    drive_vs(1'b1, 20);
    chk("lit.glitch4_a", a_frame, 32'd1);
    chk("lit.glitch4_b", b_frame, 32'd2);

    // random VS runs, led toggles, loadrom changes and resets
    for (int s = 0; s < 600; s++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        loadrom = 1'($urandom_range(0, 1));
        led = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) led = ~led;
      if ($urandom_range(0, 49) == 0) loadrom = ~loadrom;
      drive_vs(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end

    @(negedge clk);
    chk("lit.b_dump_never", 32'(b_dump_hi), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
